// File: rtl/sprite_pkg.sv
// Shared attribute record, register offsets, raster limits and the size decode
// used by the sprite compositor and its per-sprite hit test.
package sprite_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] size;
    logic       en;
  } sprite_attr_t;

  localparam logic [2:0] OFS_XLO  = 3'd0;
  localparam logic [2:0] OFS_XHI  = 3'd1;
  localparam logic [2:0] OFS_YLO  = 3'd2;
  localparam logic [2:0] OFS_YHI  = 3'd3;
  localparam logic [2:0] OFS_R    = 3'd4;
  localparam logic [2:0] OFS_G    = 3'd5;
  localparam logic [2:0] OFS_B    = 3'd6;
  localparam logic [2:0] OFS_CTRL = 3'd7;

  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] V_ACTIVE   = 10'd480;
  localparam logic [9:0] COMMIT_ROW = 10'd480;

  // size code 0..3 selects an 8/16/32/64 pixel square
  function automatic logic [6:0] size_px(input logic [1:0] size);
    return 7'd8 << size;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Avalon-MM write-only register bus carrying sprite attribute and control writes.
interface sprite_compositor_if #(
  parameter int ADDR_W = 6
);
  logic              chipselect;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [7:0]        writedata;

  // A write is accepted on every rising clock edge where chipselect && write are both
  // high; there is no waitrequest, so the slave is always ready and the master never stalls.
  modport master (output chipselect, write, address, writedata);
  modport slave  (input  chipselect, write, address, writedata);
endinterface

// File: rtl/sprite_hit_test.sv
// Combinational coverage test of one sprite against the current beam column/row.
module sprite_hit_test
  import sprite_pkg::*;
(
  input  sprite_attr_t attr,
  input  logic [9:0]   col,
  input  logic [9:0]   row,
  output logic         hit
);
  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] ext;

  // 11-bit differences keep the compare unsigned, so a sprite near the right or
  // bottom edge is clipped rather than wrapping to column/row 0.
  assign dx  = {1'b0, col} - {1'b0, attr.x};
  assign dy  = {1'b0, row} - {2'b00, attr.y};
  assign ext = {4'b0000, size_px(attr.size)};

  assign hit = attr.en
            && (col >= attr.x)           && (dx < ext)
            && (row >= {1'b0, attr.y})   && (dy < ext);
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor with shadow/active attribute banks committed at vblank.
// Define SPRITE_COLLISION_EN to build the sticky sprite-overlap flag.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          NSPRITE = 4,
  parameter int          ADDR_W  = 6,
  parameter logic [23:0] BG_RGB  = 24'h000000
) (
  input  logic               clk,
  input  logic               reset_n,
  sprite_compositor_if.slave bus,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  output logic [7:0]         pix_r,
  output logic [7:0]         pix_g,
  output logic [7:0]         pix_b,
  output logic               pix_hit,
  output logic               frame_commit,
  output logic               collision_irq
);
  localparam int                SEL_W     = ADDR_W - 3;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(8 * NSPRITE);

  sprite_attr_t shadow     [NSPRITE];
  sprite_attr_t shadow_nxt [NSPRITE];
  sprite_attr_t active     [NSPRITE];

  logic commit_mode;
  logic wr;
  logic ctrl_wr;
  logic commit_now;

  assign wr         = bus.chipselect && bus.write;
  assign ctrl_wr    = wr && (bus.address == CTRL_ADDR);
  assign commit_now = (hcount == 11'd0) && (vcount == COMMIT_ROW);

  // Next shadow value; active copies from this so a write in the commit cycle lands in both.
  always_comb begin
    for (int s = 0; s < NSPRITE; s++) begin
      shadow_nxt[s] = shadow[s];
      if (wr && (bus.address < CTRL_ADDR) && (bus.address[ADDR_W-1:3] == SEL_W'(s))) begin
        case (bus.address[2:0])
          OFS_XLO:  shadow_nxt[s].x[7:0] = bus.writedata;
          OFS_XHI:  shadow_nxt[s].x[9:8] = bus.writedata[1:0];
          OFS_YLO:  shadow_nxt[s].y[7:0] = bus.writedata;
          OFS_YHI:  shadow_nxt[s].y[8]   = bus.writedata[0];
          OFS_R:    shadow_nxt[s].r      = bus.writedata;
          OFS_G:    shadow_nxt[s].g      = bus.writedata;
          OFS_B:    shadow_nxt[s].b      = bus.writedata;
          OFS_CTRL: begin
            shadow_nxt[s].size = bus.writedata[2:1];
            shadow_nxt[s].en   = bus.writedata[0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSPRITE; s++) begin
        shadow[s] <= '0;
        active[s] <= '0;
      end
      commit_mode  <= 1'b0;
      frame_commit <= 1'b0;
    end else begin
      for (int s = 0; s < NSPRITE; s++) begin
        shadow[s] <= shadow_nxt[s];
        if (commit_mode || commit_now) active[s] <= shadow_nxt[s];
      end
      if (ctrl_wr) commit_mode <= bus.writedata[0];
      frame_commit <= commit_now;
    end
  end

  // Stage 1: per-sprite hit vector, masked to the visible raster.
  logic [9:0]         col;
  logic               in_area;
  logic [NSPRITE-1:0] hit_raw;
  logic [NSPRITE-1:0] hit_q;

  assign col     = hcount[10:1];
  assign in_area = (col < H_ACTIVE) && (vcount < V_ACTIVE);

  for (genvar s = 0; s < NSPRITE; s++) begin : g_hit
    sprite_hit_test u_hit (
      .attr (active[s]),
      .col  (col),
      .row  (vcount),
      .hit  (hit_raw[s])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hit_q <= '0;
    else          hit_q <= in_area ? hit_raw : '0;
  end

  // Stage 2: lowest index wins, so scan downward and let later matches override.
  logic [23:0] win_rgb;
  logic        win_hit;

  always_comb begin
    win_rgb = BG_RGB;
    win_hit = 1'b0;
    for (int s = NSPRITE - 1; s >= 0; s--) begin
      if (hit_q[s]) begin
        win_rgb = {active[s].r, active[s].g, active[s].b};
        win_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_r   <= 8'd0;
      pix_g   <= 8'd0;
      pix_b   <= 8'd0;
      pix_hit <= 1'b0;
    end else begin
      {pix_r, pix_g, pix_b} <= win_rgb;
      pix_hit               <= win_hit;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic overlap;
  logic irq_clr;

  // Clearing the lowest set bit leaves something only if two or more sprites hit.
  assign overlap = (hit_q & (hit_q - NSPRITE'(1))) != '0;
  assign irq_clr = ctrl_wr && bus.writedata[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     collision_irq <= 1'b0;
    else if (overlap) collision_irq <= 1'b1;
    else if (irq_clr) collision_irq <= 1'b0;
  end
`else
  assign collision_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor: commit timing, clipping,
// priority, collision flag and register-map edge cases.
module tb_sprite_compositor;
  localparam int                ADDR_W = 6;
  localparam logic [ADDR_W-1:0] CTRL_A = 6'd32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] hcount = 11'd2;
  logic [9:0]  vcount = 10'd500;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_hit, frame_commit, collision_irq;
  int          checks = 0;
  int          errors = 0;

  sprite_compositor_if #(.ADDR_W(ADDR_W)) bus ();

  sprite_compositor #(.NSPRITE(4), .ADDR_W(ADDR_W), .BG_RGB(24'h000000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .hcount        (hcount),
    .vcount        (vcount),
    .pix_r         (pix_r),
    .pix_g         (pix_g),
    .pix_b         (pix_b),
    .pix_hit       (pix_hit),
    .frame_commit  (frame_commit),
    .collision_irq (collision_irq)
  );

  // clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // driver tasks
  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic set_beam(input int h, input int v);
    @(negedge clk);
    hcount = 11'(h);
    vcount = 10'(v);
  endtask

  task automatic park();
    set_beam(2, 500);
  endtask

  task automatic prog_sprite(input int s, input logic [9:0] x, input logic [8:0] y,
                             input logic [23:0] rgb, input logic [1:0] size, input logic en);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'(8 * s);
    bus_write(base + 6'd0, x[7:0]);
    bus_write(base + 6'd1, {6'd0, x[9:8]});
    bus_write(base + 6'd2, y[7:0]);
    bus_write(base + 6'd3, {7'd0, y[8]});
    bus_write(base + 6'd4, rgb[23:16]);
    bus_write(base + 6'd5, rgb[15:8]);
    bus_write(base + 6'd6, rgb[7:0]);
    bus_write(base + 6'd7, {5'd0, size, en});
  endtask

  task automatic probe(input int col, input int row, output logic [23:0] rgb, output logic hit);
    set_beam(2 * col, row);
    @(posedge clk); @(posedge clk); #1;
    rgb = {pix_r, pix_g, pix_b};
    hit = pix_hit;
  endtask

  task automatic do_commit(output logic fc_on, output logic fc_off);
    set_beam(0, 480);
    @(posedge clk); #1 fc_on = frame_commit;
    park();
    @(posedge clk); #1 fc_off = frame_commit;
  endtask

  // scenarios
  task automatic test_reset();
    logic [23:0] rgb; logic hit, on, off;
    int pc[5] = '{100, 103, 0, 639, 320};
    int pr[5] = '{50, 53, 0, 479, 240};
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({pix_r, pix_g, pix_b, pix_hit, frame_commit, collision_irq} !== 27'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {pix_r, pix_g, pix_b, pix_hit, frame_commit, collision_irq});
    end
    @(negedge clk); reset_n = 1'b1;
    prog_sprite(0, 10'd100, 9'd50, 24'hFF0000, 2'd0, 1'b1);
    do_commit(on, off);
    probe(100, 50, rgb, hit);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL reset_prehit: got %b want 1", hit); end
    @(negedge clk); #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({pix_r, pix_g, pix_b, pix_hit, frame_commit, collision_irq} !== 27'd0) begin
      errors++; $display("FAIL reset_async: got %h want 0", {pix_r, pix_g, pix_b, pix_hit, frame_commit, collision_irq});
    end
    @(negedge clk); reset_n = 1'b1;
    do_commit(on, off);
    for (int i = 0; i < 5; i++) begin
      probe(pc[i], pr[i], rgb, hit);
      checks++;
      if ({hit, rgb} !== 25'd0) begin
        errors++; $display("FAIL reset_frame_blank col %0d row %0d: got %h want 0", pc[i], pr[i], {hit, rgb});
      end
    end
  endtask

  task automatic test_basic();
    logic [23:0] rgb; logic hit, on, off;
    logic [24:0] exp_q[$];
    logic [24:0] exp;
    int   tc[8] = '{100, 107, 108, 99, 100, 100, 100, 104};
    int   tr[8] = '{50, 57, 50, 50, 57, 58, 49, 54};
    logic th[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    prog_sprite(0, 10'd100, 9'd50, 24'hFF0000, 2'd0, 1'b1);
    probe(100, 50, rgb, hit);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL basic_uncommitted: got %b want 0", hit); end
    do_commit(on, off);
    checks++;
    if ({on, off} !== 2'b10) begin errors++; $display("FAIL basic_commit_pulse: got %b want 10", {on, off}); end
    probe(0, 10, rgb, hit);
    set_beam(200, 50);
    @(posedge clk); #1;
    checks++;
    if (pix_hit !== 1'b0) begin errors++; $display("FAIL basic_latency1: got %b want 0", pix_hit); end
    @(posedge clk); #1;
    checks++;
    if ({pix_hit, pix_r, pix_g, pix_b} !== {1'b1, 24'hFF0000}) begin
      errors++; $display("FAIL basic_latency2: got %h want %h", {pix_hit, pix_r, pix_g, pix_b}, {1'b1, 24'hFF0000});
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(th[i] ? {1'b1, 24'hFF0000} : 25'd0);
      probe(tc[i], tr[i], rgb, hit);
      exp = exp_q.pop_front();
      checks++;
      if ({hit, rgb} !== exp) begin
        errors++; $display("FAIL basic_pixel col %0d row %0d: got %h want %h", tc[i], tr[i], {hit, rgb}, exp);
      end
    end
    set_beam(215, 50);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (pix_hit !== 1'b1) begin errors++; $display("FAIL basic_odd_hcount: got %b want 1", pix_hit); end
  endtask

  task automatic test_tear();
    logic [23:0] rgb; logic hit, on, off;
    set_beam(100, 53);
    bus_write(6'd0, 8'd200);
    probe(100, 53, rgb, hit);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL tear_old_pos: got %b want 1", hit); end
    probe(200, 53, rgb, hit);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL tear_new_early: got %b want 0", hit); end
    do_commit(on, off);
    probe(200, 53, rgb, hit);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL tear_next_frame: got %b want 1", hit); end
    bus_write(CTRL_A, 8'h01);
    bus_write(6'd0, 8'd100);
    probe(100, 53, rgb, hit);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL tear_immediate: got %b want 1", hit); end
    do_commit(on, off);
    checks++;
    if (on !== 1'b1) begin errors++; $display("FAIL tear_mode1_pulse: got %b want 1", on); end
    bus_write(CTRL_A, 8'h00);
    bus_write(6'd0, 8'd150);
    probe(100, 53, rgb, hit);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL tear_mode0_again: got %b want 1", hit); end
  endtask

  task automatic test_priority();
    logic [23:0] rgb; logic hit, on, off;
    int          tc[6] = '{636, 639, 640, 639, 0, 636};
    int          tr[6] = '{476, 479, 476, 480, 476, 475};
    logic [24:0] te[6] = '{{1'b1, 24'hFF0000}, {1'b1, 24'hFF0000}, 25'd0, 25'd0, 25'd0, 25'd0};
    checks++;
    if (collision_irq !== 1'b0) begin errors++; $display("FAIL prio_irq_idle: got %b want 0", collision_irq); end
    prog_sprite(0, 10'd636, 9'd476, 24'hFF0000, 2'd0, 1'b1);
    prog_sprite(1, 10'd636, 9'd476, 24'h00FF00, 2'd1, 1'b1);
    do_commit(on, off);
    for (int i = 0; i < 6; i++) begin
      probe(tc[i], tr[i], rgb, hit);
      checks++;
      if ({hit, rgb} !== te[i]) begin
        errors++; $display("FAIL prio_pixel col %0d row %0d: got %h want %h", tc[i], tr[i], {hit, rgb}, te[i]);
      end
    end
    bus_write(6'd7, 8'h00);
    do_commit(on, off);
    probe(639, 479, rgb, hit);
    checks++;
    if ({hit, rgb} !== {1'b1, 24'h00FF00}) begin
      errors++; $display("FAIL prio_sprite1_alone: got %h want %h", {hit, rgb}, {1'b1, 24'h00FF00});
    end
    bus_write(6'd7, 8'h01);
    do_commit(on, off);
  endtask

  task automatic test_collision();
    logic [23:0] rgb; logic hit;
`ifdef SPRITE_COLLISION_EN
    checks++;
    if (collision_irq !== 1'b1) begin errors++; $display("FAIL coll_held: got %b want 1", collision_irq); end
    park();
    bus_write(CTRL_A, 8'h02);
    #1;
    checks++;
    if (collision_irq !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b want 0", collision_irq); end
    probe(639, 479, rgb, hit);
    checks++;
    if (collision_irq !== 1'b1) begin errors++; $display("FAIL coll_set: got %b want 1", collision_irq); end
    park();
    repeat (4) @(posedge clk); #1;
    checks++;
    if (collision_irq !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %b want 1", collision_irq); end
    bus_write(CTRL_A, 8'h02);
    set_beam(2 * 636, 476);
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = CTRL_A; bus.writedata = 8'h02;
    @(posedge clk); #1;
    checks++;
    if (collision_irq !== 1'b1) begin errors++; $display("FAIL coll_set_beats_clear: got %b want 1", collision_irq); end
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
    park();
    repeat (2) @(posedge clk);
    bus_write(CTRL_A, 8'h02);
    probe(320, 240, rgb, hit);
    checks++;
    if (collision_irq !== 1'b0) begin errors++; $display("FAIL coll_no_overlap: got %b want 0", collision_irq); end
`else
    probe(636, 476, rgb, hit);
    checks++;
    if (collision_irq !== 1'b0) begin errors++; $display("FAIL coll_disabled: got %b want 0", collision_irq); end
    park();
    bus_write(CTRL_A, 8'h02);
    #1;
    checks++;
    if (collision_irq !== 1'b0) begin errors++; $display("FAIL coll_disabled_clr: got %b want 0", collision_irq); end
`endif
  endtask

  task automatic test_edge();
    logic [23:0] rgb; logic hit, on, off;
    prog_sprite(0, 10'd100, 9'd50, 24'hFF0000, 2'd0, 1'b1);
    bus_write(6'd33, 8'hFF);
    bus_write(6'd63, 8'hFF);
    do_commit(on, off);
    probe(100, 50, rgb, hit);
    checks++;
    if ({hit, rgb} !== {1'b1, 24'hFF0000}) begin
      errors++; $display("FAIL edge_unmapped: got %h want %h", {hit, rgb}, {1'b1, 24'hFF0000});
    end
    probe(636, 476, rgb, hit);
    checks++;
    if ({hit, rgb} !== {1'b1, 24'h00FF00}) begin
      errors++; $display("FAIL edge_sprite1_kept: got %h want %h", {hit, rgb}, {1'b1, 24'h00FF00});
    end
    bus_write(6'd0, 8'd120);
    probe(100, 50, rgb, hit);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL edge_mode_unchanged: got %b want 1", hit); end
    bus_write(6'd0, 8'd100);
    bus_write(6'd1, 8'hFF);
    do_commit(on, off);
    probe(100, 50, rgb, hit);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL edge_xhi_ff: got %b want 0", hit); end
    bus_write(6'd1, 8'h00);
    bus_write(6'd3, 8'hFF);
    do_commit(on, off);
    probe(100, 306, rgb, hit);
    checks++;
    if ({hit, rgb} !== {1'b1, 24'hFF0000}) begin
      errors++; $display("FAIL edge_yhi_ff: got %h want %h", {hit, rgb}, {1'b1, 24'hFF0000});
    end
    bus_write(6'd3, 8'h00);
    bus_write(6'd7, 8'hFF);
    do_commit(on, off);
    probe(163, 113, rgb, hit);
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL edge_size64_in: got %b want 1", hit); end
    probe(164, 50, rgb, hit);
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL edge_size64_out: got %b want 0", hit); end
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd480;
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 6'd4; bus.writedata = 8'h12;
    @(posedge clk); #1;
    checks++;
    if (frame_commit !== 1'b1) begin errors++; $display("FAIL edge_commit_pulse: got %b want 1", frame_commit); end
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
    hcount = 11'd2; vcount = 10'd500;
    probe(100, 50, rgb, hit);
    checks++;
    if ({hit, rgb} !== {1'b1, 24'h120000}) begin
      errors++; $display("FAIL edge_commit_write: got %h want %h", {hit, rgb}, {1'b1, 24'h120000});
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_tear();
    test_priority();
    test_collision();
    test_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
